// File: rtl/prime_number_generator.sv
// prime_number_generator: streams every prime in [2, 2^WIDTH-1] in order.
// Define PRIME_GEN_COUNT_EN to add the prime_count output.
module prime_number_generator #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             ready,
    output logic [WIDTH-1:0] prime_out,
    output logic             valid,
    output logic             busy,
    output logic             done
`ifdef PRIME_GEN_COUNT_EN
    ,
    output logic [WIDTH-1:0] prime_count
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        DIV,
        EMIT,
        DONE
    } state_t;

    localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO = WIDTH'(2);

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0]   cand;
    logic [WIDTH-1:0]   d;
    logic [WIDTH-1:0]   rem;
    logic [2*WIDTH-1:0] d_wide;
    logic [2*WIDTH-1:0] cand_wide;
    logic [2*WIDTH-1:0] d_sq;
    logic               is_prime;
    logic               rem_zero;
    logic               rem_lt;
    logic               at_max;
    logic               start_ok;

    // Divisor square is formed at double width so it never overflows.
    assign d_wide    = {{WIDTH{1'b0}}, d};
    assign cand_wide = {{WIDTH{1'b0}}, cand};
    assign d_sq      = d_wide * d_wide;
    assign is_prime  = d_sq > cand_wide;
    assign rem_zero  = rem == '0;
    assign rem_lt    = rem < d;
    assign at_max    = cand == MAX;
    assign start_ok  = start && (state == IDLE || state == DONE);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; the composite step goes straight to INIT or DONE
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start) state_nxt = INIT;
            INIT: state_nxt = DIV;
            DIV: begin
                if (is_prime) begin
                    state_nxt = EMIT;
                end else if (rem_zero) begin
                    state_nxt = at_max ? DONE : INIT;
                end
            end
            EMIT: if (ready) state_nxt = at_max ? DONE : INIT;
            DONE: if (start) state_nxt = INIT;
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs decoded from state
    always_comb begin
        valid = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        unique case (state)
            INIT: busy = 1'b1;
            DIV:  busy = 1'b1;
            EMIT: begin
                busy  = 1'b1;
                valid = 1'b1;
            end
            DONE: done = 1'b1;
            default: ;
        endcase
    end

    // Trial division by repeated subtraction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cand      <= '0;
            d         <= '0;
            rem       <= '0;
            prime_out <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: if (start) cand <= TWO;
                INIT: begin
                    d   <= TWO;
                    rem <= cand;
                end
                DIV: begin
                    if (is_prime) begin
                        prime_out <= cand;
                    end else if (rem_zero) begin
                        if (!at_max) cand <= cand + ONE;
                    end else if (rem_lt) begin
                        d   <= d + ONE;
                        rem <= cand;
                    end else begin
                        rem <= rem - d;
                    end
                end
                EMIT: if (ready && !at_max) cand <= cand + ONE;
                default: ;
            endcase
        end
    end

`ifdef PRIME_GEN_COUNT_EN
    // Count accepted primes; an accepted start begins a new tally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prime_count <= '0;
        end else if (start_ok) begin
            prime_count <= '0;
        end else if (valid && ready) begin
            prime_count <= prime_count + ONE;
        end
    end
`else
    logic unused_start_ok;
    assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_prime_number_generator.sv
// Scoreboard bench for prime_number_generator (WIDTH=4 and WIDTH=5 instances).
`timescale 1ns/1ps
module tb_prime_number_generator;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       ready;
    logic [3:0] prime_out;
    logic       valid;
    logic       busy;
    logic       done;

    logic       start5;
    logic       ready5;
    logic [4:0] prime_out5;
    logic       valid5;
    logic       busy5;
    logic       done5;

`ifdef PRIME_GEN_COUNT_EN
    logic [3:0] prime_count;
    logic [4:0] prime_count5;
`endif

    int checks = 0;
    int errors = 0;

    logic [3:0] exp_q[$];
    logic [4:0] exp_q5[$];

    logic [3:0] p4[6]  = '{4'd2, 4'd3, 4'd5, 4'd7, 4'd11, 4'd13};
    logic [4:0] p5[11] = '{5'd2, 5'd3, 5'd5, 5'd7, 5'd11, 5'd13,
                           5'd17, 5'd19, 5'd23, 5'd29, 5'd31};

    always #5 clk = ~clk;

    prime_number_generator #(.WIDTH(4)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .ready     (ready),
        .prime_out (prime_out),
        .valid     (valid),
        .busy      (busy),
        .done      (done)
`ifdef PRIME_GEN_COUNT_EN
        ,
        .prime_count (prime_count)
`endif
    );

    prime_number_generator #(.WIDTH(5)) u_dut5 (
        .clk       (clk),
        .reset     (reset),
        .start     (start5),
        .ready     (ready5),
        .prime_out (prime_out5),
        .valid     (valid5),
        .busy      (busy5),
        .done      (done5)
`ifdef PRIME_GEN_COUNT_EN
        ,
        .prime_count (prime_count5)
`endif
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push_all4();
        foreach (p4[i]) exp_q.push_back(p4[i]);
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n = 0;
        while (!valid && n < budget) begin
            tick();
            n++;
        end
        check(name, int'(valid), 1);
    endtask

    task automatic wait_prime(input logic [3:0] p, input int budget);
        int n = 0;
        while (!(valid && prime_out == p) && n < budget) begin
            tick();
            n++;
        end
        check("wait_prime_shown", int'(valid && prime_out == p), 1);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        check("done_reached", int'(done), 1);
        check("done_valid_low", int'(valid), 0);
        check("done_busy_low", int'(busy), 0);
        check("queue_drained", exp_q.size(), 0);
`ifdef PRIME_GEN_COUNT_EN
        check("prime_count", int'(prime_count), 6);
`endif
    endtask

    // Monitor: each handshake on the WIDTH=4 instance pops one expectation
    always @(negedge clk) begin
        if (valid && ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_prime: got %0d expected none",
                         prime_out);
            end else begin
                check("prime_seq", int'(prime_out), int'(exp_q.pop_front()));
            end
        end
    end

    // Monitor for the WIDTH=5 instance
    always @(negedge clk) begin
        if (valid5 && ready5) begin
            if (exp_q5.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_prime5: got %0d expected none",
                         prime_out5);
            end else begin
                check("prime_seq5", int'(prime_out5), int'(exp_q5.pop_front()));
            end
        end
    end

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        ready  = 1'b1;
        start5 = 1'b0;
        ready5 = 1'b1;
        repeat (3) tick();
        check("rst_prime_out", int'(prime_out), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        reset = 1'b0;
        tick();

        // Full run with ready high, first-prime latency
        push_all4();
        pulse_start();
        check("lat_init_busy", int'(busy), 1);
        check("lat_init_valid", int'(valid), 0);
        tick();
        check("lat_div_valid", int'(valid), 0);
        tick();
        check("lat_emit_valid", int'(valid), 1);
        check("lat_emit_prime", int'(prime_out), 2);
        wait_done(400);

        // Restart from DONE under backpressure
        ready = 1'b0;
        push_all4();
        pulse_start();
        check("restart_done_clear", int'(done), 0);
        for (int k = 0; k < 6; k++) begin
            wait_valid("bp_wait_valid", 100);
            if (prime_out == 4'd5) begin
                for (int h = 0; h < 7; h++) begin
                    tick();
                    check("bp_hold_valid", int'(valid), 1);
                    check("bp_hold_prime", int'(prime_out), 5);
                end
                ready = 1'b1;
                tick();
                ready = 1'b0;
                check("bp_valid_drop", int'(valid), 0);
            end else begin
                ready = 1'b1;
                tick();
                ready = 1'b0;
            end
        end
        ready = 1'b1;
        wait_done(400);

        // Start pulses while busy are ignored
        push_all4();
        pulse_start();
        wait_prime(4'd7, 200);
        tick();
        for (int i = 0; i < 12; i++) begin
            start = (i % 2) == 0;
            tick();
        end
        start = 1'b0;
        check("busy_during_pulses", int'(busy), 1);
        wait_done(400);

        // Reset during the test of candidate 11
        foreach (p4[i]) if (i < 4) exp_q.push_back(p4[i]);
        pulse_start();
        wait_prime(4'd7, 200);
        tick();
        repeat (30) tick();
        check("pre_rst_busy", int'(busy), 1);
        check("pre_rst_valid", int'(valid), 0);
        reset = 1'b1;
        #1;
        check("mid_rst_prime_out", int'(prime_out), 0);
        check("mid_rst_valid", int'(valid), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_done", int'(done), 0);
        check("mid_rst_queue", exp_q.size(), 0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        push_all4();
        pulse_start();
        wait_done(400);

        // WIDTH=5: last prime is MAX, DONE follows its acceptance
        foreach (p5[i]) exp_q5.push_back(p5[i]);
        start5 = 1'b1;
        tick();
        start5 = 1'b0;
        begin
            int n = 0;
            while (!(valid5 && prime_out5 == 5'd31) && n < 3000) begin
                tick();
                n++;
            end
            check("w5_last_shown", int'(valid5 && prime_out5 == 5'd31), 1);
        end
        tick();
        check("w5_done", int'(done5), 1);
        check("w5_valid_low", int'(valid5), 0);
        check("w5_busy_low", int'(busy5), 0);
        check("w5_queue", exp_q5.size(), 0);
`ifdef PRIME_GEN_COUNT_EN
        check("w5_prime_count", int'(prime_count5), 11);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prime_number_generator.md
Name: prime_number_generator

Overview:
Sequential counterpart to the team's combinational prime detector: instead of flagging whether an input is prime, it produces every prime in [2, 2^WIDTH-1] in ascending order. Primality is tested by a trial-division FSM using repeated subtraction, with no divider. Primes leave on a valid/ready handshake to a downstream consumer such as a display or the detector bench used as a checker.

Parameters:
WIDTH, 4, bit width of candidates and prime_out; largest candidate is MAX = 2^WIDTH-1.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; begins a sequence from 2 when in IDLE or DONE
ready  input  1  consumer accepts prime_out when high with valid
prime_out  output  WIDTH  current prime, stable while valid
valid  output  1  prime_out holds an unaccepted prime
busy  output  1  high in INIT, DIV, EMIT
done  output  1  level; all primes up to MAX have been emitted

Behaviour:
- Reset (async, any state): state=IDLE, prime_out=0, valid=0, busy=0, done=0; internal cand, d and rem cleared. Takes effect immediately, including mid-test and mid-EMIT.
- Registers: cand (WIDTH), d divisor (WIDTH), rem (WIDTH). d*d is evaluated at 2*WIDTH bits with no overflow.
- IDLE: on start: cand<=2 -> INIT. Otherwise stay.
- INIT: d<=2, rem<=cand -> DIV. Takes 1 cycle.
- DIV, priority order:
  1) d*d > cand: prime; prime_out<=cand -> EMIT.
  2) rem==0: composite -> NEXT.
  3) rem<d: not divisible by d; d<=d+1, rem<=cand; stay in DIV.
  4) Otherwise rem<=rem-d; stay in DIV.
- NEXT: if cand==MAX -> DONE; else cand<=cand+1 -> INIT. NEXT may be a registered state or folded into the DIV transition, but the cand/INIT sequence must match.
- EMIT: valid=1. prime_out and valid are held unchanged while ready=0. On valid&&ready: if cand==MAX -> DONE, else cand<=cand+1 -> INIT. valid drops on the edge after acceptance.
- DONE: done=1, valid=0. done stays high until start is sampled; then it clears and cand<=2 -> INIT.
- start is ignored in INIT, DIV and EMIT.
- Latency for the first prime: start sampled on edge k; valid is high after edge k+2 with prime_out=2 (INIT at k, DIV at k+1, EMIT at k+2).
- Cycle counts are fully determined by the algorithm above; the bench may check them exactly.
- No wrap-around: cand never increments past MAX. For WIDTH=4, MAX=15 is composite, so DONE is entered from 15's test.

Optional Feature:
PRIME_GEN_COUNT_EN
- Defined: adds output port prime_count (WIDTH bits), reset to 0.
  - Increments on each valid&&ready handshake.
  - Clears when start is accepted.
  - Holds its final value in DONE.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
1. WIDTH=4, ready tied 1, pulse start -> accepted sequence 2,3,5,7,11,13; then done=1, valid=0, busy=0; prime_count=6 if PRIME_GEN_COUNT_EN is defined.
2. Start on edge k with ready=1 -> valid=1, prime_out=2 after edge k+2. Cand 4: DIV subtracts to rem=0, no EMIT, and 5 is emitted next.
3. Backpressure: hold ready=0 for 7 cycles while prime_out=5 -> valid stays 1 and prime_out stays 5; raise ready -> 5 is accepted exactly once, and the next valid shows 7.
4. Pulse start while busy (during the test of cand 9) -> ignored; the sequence continues 11,13 with no restart.
5. Assert reset during the DIV of cand 11 -> all outputs 0 immediately, state IDLE. A later start restarts from 2.
6. From DONE, pulse start -> done clears and the sequence 2..13 repeats. With WIDTH=5, the last prime is 31 (=MAX), and DONE follows its acceptance.
